// File: rtl/neo_coin_pkg.sv
`timescale 1ns/1ps
// Shared types and widths for the coin counter / lockout driver.
// Holds the channel FSM encoding, timer width and pending-count width.
// No logic; imported by the channel and top-level modules.
package neo_coin_pkg;

  localparam int TIMER_W = 21;
  localparam int PEND_W  = 4;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } coin_state_e;

  // Timer reload value for a phase lasting 'cycles' clock cycles.
  function automatic logic [TIMER_W-1:0] timer_load(input int cycles);
    return TIMER_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/neo_coin_chan.sv
`timescale 1ns/1ps
// One coin counter channel: rise detect, pending queue, pulse FSM and timer.
// Latency: synchronized rise -> pending +1 after 2 cycles, drive after 1 more.
// No backpressure: requests queue in a 4-bit saturating count, overflow is sticky.
module neo_coin_chan
  import neo_coin_pkg::*;
#(
  parameter int PULSE_ON  = 1200000,
  parameter int PULSE_OFF = 1200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s,
  input  logic              ovf_clr,
  output logic              drv,
  output logic [PEND_W-1:0] pend,
  output logic              ovf
);

  localparam logic [TIMER_W-1:0] ON_LOAD  = timer_load(PULSE_ON);
  localparam logic [TIMER_W-1:0] OFF_LOAD = timer_load(PULSE_OFF);

  logic               s_d;
  logic               req;
  coin_state_e        state;
  coin_state_e        state_nxt;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_nxt;
  logic               start;
  logic               ovf_hit;
  logic               timer_zero;
  logic               pend_nz;

  assign timer_zero = (timer == '0);
  assign pend_nz    = (pend != '0);
  assign ovf_hit    = req & ~start & (pend == PEND_MAX);

  // Rising-edge detect; the request is registered so it lands on pend one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_d <= 1'b0;
      req <= 1'b0;
    end else begin
      s_d <= s;
      req <= s & ~s_d;
    end
  end

  // Next-state, timer reload/decrement and start strobe.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    start     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pend_nz) begin
          state_nxt = ST_ON;
          timer_nxt = ON_LOAD;
          start     = 1'b1;
        end
      end
      ST_ON: begin
        if (timer_zero) begin
          state_nxt = ST_OFF;
          timer_nxt = OFF_LOAD;
        end else begin
          timer_nxt = timer - TIMER_W'(1);
        end
      end
      ST_OFF: begin
        if (timer_zero) begin
          if (pend_nz) begin
            state_nxt = ST_ON;
            timer_nxt = ON_LOAD;
            start     = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          timer_nxt = timer - TIMER_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // State, timer and registered solenoid drive (high exactly while in ON).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      timer <= '0;
      drv   <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      drv   <= (state_nxt == ST_ON);
    end
  end

  // Pending count: +req -start, saturating at 15; coincident req and start cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      case ({req, start})
        2'b10:   if (!ovf_hit) pend <= pend + PEND_W'(1);
        2'b01:   pend <= pend - PEND_W'(1);
        default: pend <= pend;
      endcase
    end
  end

  // Sticky overflow; a new overflow wins over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else begin
      ovf <= ovf_hit | (ovf & ~ovf_clr);
    end
  end

endmodule

// File: rtl/neo_coin_drv.sv
`timescale 1ns/1ps
// Coin counter solenoid and lockout coil driver, two channels.
// Latency: lockout 2 cycles; counter rise to drive 4 cycles from first sample.
// No backpressure: counter rises queue per channel, overflow flagged sticky.
module neo_coin_drv
  import neo_coin_pkg::*;
#(
  parameter int PULSE_ON  = 1200000,
  parameter int PULSE_OFF = 1200000
) (
  input  logic              CLK_24M,
  input  logic              RESET,
  input  logic              COUNTER1,
  input  logic              COUNTER2,
  input  logic              LOCKOUT1,
  input  logic              LOCKOUT2,
  input  logic              OVF_CLR,
  output logic              COIN_DRV1,
  output logic              COIN_DRV2,
  output logic              LOCK_DRV1,
  output logic              LOCK_DRV2,
  output logic [PEND_W-1:0] PEND1,
  output logic [PEND_W-1:0] PEND2,
  output logic              OVF1,
  output logic              OVF2
);

  // Bit order: [0]=COUNTER1, [1]=COUNTER2, [2]=LOCKOUT1, [3]=LOCKOUT2.
  logic [3:0] sync1;
  logic [3:0] sync2;

  // Two-flop synchronizers for all four asynchronous level inputs.
  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {LOCKOUT2, LOCKOUT1, COUNTER2, COUNTER1};
      sync2 <= sync1;
    end
  end

  // Lockout coils follow the synchronized levels directly.
  assign LOCK_DRV1 = sync2[2];
  assign LOCK_DRV2 = sync2[3];

  neo_coin_chan #(
    .PULSE_ON  (PULSE_ON),
    .PULSE_OFF (PULSE_OFF)
  ) u_chan1 (
    .clk     (CLK_24M),
    .rst     (RESET),
    .s       (sync2[0]),
    .ovf_clr (OVF_CLR),
    .drv     (COIN_DRV1),
    .pend    (PEND1),
    .ovf     (OVF1)
  );

  neo_coin_chan #(
    .PULSE_ON  (PULSE_ON),
    .PULSE_OFF (PULSE_OFF)
  ) u_chan2 (
    .clk     (CLK_24M),
    .rst     (RESET),
    .s       (sync2[1]),
    .ovf_clr (OVF_CLR),
    .drv     (COIN_DRV2),
    .pend    (PEND2),
    .ovf     (OVF2)
  );

endmodule
